// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, result packet type and sizing helper for the CDB arbiter.
package cdb_arbiter_pkg;
    localparam int CDB_ROB_IX_W = 3;
    localparam int CDB_XLEN     = 32;

    typedef struct packed {
        logic [CDB_ROB_IX_W-1:0] rob_ix;
        logic [CDB_XLEN-1:0]     value;
        logic [CDB_XLEN-1:0]     dest;
    } cdb_pkt_t;

    // Width of an index over n items; a single item still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-FU result FIFO: power-of-2 depth, synchronous flush, head visible combinationally.
module cdb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 67
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         flush_in,
    input  logic         push_in,
    input  logic         pop_in,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] head_out,
    output logic         full_out,
    output logic         empty_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_in) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_in)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push_in) - CW'(pop_in);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_in) begin
        if (push_in && !flush_in) mem_q[wr_ptr_q] <= data_in;
    end

    assign head_out  = mem_q[rd_ptr_q];
    assign full_out  = (cnt_q == CW'(DEPTH));
    assign empty_out = (cnt_q == '0);
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered common data bus among N_FU result FIFOs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_FU       = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_IX_W   = CDB_ROB_IX_W,
    parameter int XLEN       = CDB_XLEN,
    parameter int SW         = idx_w(N_FU)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       flush_in,
    input  logic [N_FU-1:0]            fu_valid_in,
    input  logic [N_FU*ROB_IX_W-1:0]   fu_rob_ix_in,
    input  logic [N_FU*XLEN-1:0]       fu_value_in,
    input  logic [N_FU*XLEN-1:0]       fu_dest_in,
    output logic [N_FU-1:0]            fu_ready_out,
    output logic                       cdb_valid_out,
    output logic [ROB_IX_W-1:0]        cdb_rob_ix_out,
    output logic [XLEN-1:0]            cdb_value_out,
    output logic [XLEN-1:0]            cdb_dest_out,
    output logic [SW-1:0]              cdb_src_out
);
    localparam int PW = ROB_IX_W + 2 * XLEN;

    logic [N_FU-1:0]          full, empty, push, pop;
    logic [N_FU-1:0][PW-1:0]  head;
    logic                     found;
    logic [SW-1:0]            win;
    int                       idx;

    logic [SW-1:0] rr_ptr_q, rr_ptr_d, src_q, src_d;
    logic          cdb_valid_q, cdb_valid_d;
    logic [PW-1:0] pkt_q, pkt_d;

    // Ready comes from registered counts only and is held low during reset.
    assign fu_ready_out = {N_FU{rst_n_in}} & ~full;
    assign push         = fu_valid_in & fu_ready_out;

    for (genvar k = 0; k < N_FU; k++) begin : g_fu
        cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(PW)) u_fifo (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .flush_in  (flush_in),
            .push_in   (push[k]),
            .pop_in    (pop[k]),
            .data_in   ({fu_rob_ix_in[k*ROB_IX_W +: ROB_IX_W],
                         fu_value_in[k*XLEN +: XLEN],
                         fu_dest_in[k*XLEN +: XLEN]}),
            .head_out  (head[k]),
            .full_out  (full[k]),
            .empty_out (empty[k])
        );
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_FU; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_FU;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    always_comb begin
        pop         = '0;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        pkt_d       = pkt_q;
        src_d       = src_q;
        if (flush_in) begin
            rr_ptr_d = '0;
        end else if (found) begin
            pop[win]    = 1'b1;
            rr_ptr_d    = (int'(win) == N_FU - 1) ? '0 : win + SW'(1);
            cdb_valid_d = 1'b1;
            pkt_d       = head[win];
            src_d       = win;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            pkt_q       <= '0;
            src_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            pkt_q       <= pkt_d;
            src_q       <= src_d;
        end
    end

    assign cdb_valid_out = cdb_valid_q;
    assign {cdb_rob_ix_out, cdb_value_out, cdb_dest_out} = pkt_q;
    assign cdb_src_out   = src_q;

    // An FU must hold its result while its FIFO reports not ready.
    a_no_push_when_full: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        (fu_valid_in & ~fu_ready_out) == '0);
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, rotation, backpressure, flush, reset, fairness.
module tb_cdb_arbiter;
    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         flush_in;
    logic [3:0]   fu_valid_in;
    logic [11:0]  fu_rob_ix_in;
    logic [127:0] fu_value_in;
    logic [127:0] fu_dest_in;
    logic [3:0]   fu_ready_out;
    logic         cdb_valid_out;
    logic [2:0]   cdb_rob_ix_out;
    logic [31:0]  cdb_value_out;
    logic [31:0]  cdb_dest_out;
    logic [1:0]   cdb_src_out;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    cdb_arbiter #(.N_FU(4), .FIFO_DEPTH(2), .ROB_IX_W(3), .XLEN(32)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .flush_in       (flush_in),
        .fu_valid_in    (fu_valid_in),
        .fu_rob_ix_in   (fu_rob_ix_in),
        .fu_value_in    (fu_value_in),
        .fu_dest_in     (fu_dest_in),
        .fu_ready_out   (fu_ready_out),
        .cdb_valid_out  (cdb_valid_out),
        .cdb_rob_ix_out (cdb_rob_ix_out),
        .cdb_value_out  (cdb_value_out),
        .cdb_dest_out   (cdb_dest_out),
        .cdb_src_out    (cdb_src_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_fu(input int k, input logic v, input logic [2:0] rob,
                          input logic [31:0] val, input logic [31:0] dst);
        fu_valid_in[k]          = v;
        fu_rob_ix_in[k*3 +: 3]  = rob;
        fu_value_in[k*32 +: 32] = val;
        fu_dest_in[k*32 +: 32]  = dst;
    endtask

    // Two FUs stream n results each, respecting ready; checks alternation and per-FU order.
    task automatic run_pair(input string nm, input int a, input int b, input int n);
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] e;
        int sa, sb, got, prev, cyc;
        bit nra, nrb;
        sa = 0; sb = 0; got = 0; prev = -1; cyc = 0; nra = 0; nrb = 0;
        while (got < 2 * n && cyc < 200) begin
            if (cdb_valid_out) begin
                got++;
                chk({nm, "_src_member"}, 64'(cdb_src_out == 2'(a) || cdb_src_out == 2'(b)), 64'd1);
                if (prev >= 0) chk({nm, "_alternate"}, 64'(int'(cdb_src_out) != prev), 64'd1);
                prev = int'(cdb_src_out);
                if (int'(cdb_src_out) == a) begin
                    chk({nm, "_sb_a_nonempty"}, 64'(qa.size() != 0), 64'd1);
                    if (qa.size() != 0) begin
                        e = qa.pop_front();
                        chk({nm, "_value_a"}, 64'(cdb_value_out), 64'(e));
                        chk({nm, "_rob_a"}, 64'(cdb_rob_ix_out), 64'(e[2:0]));
                    end
                end else begin
                    chk({nm, "_sb_b_nonempty"}, 64'(qb.size() != 0), 64'd1);
                    if (qb.size() != 0) begin
                        e = qb.pop_front();
                        chk({nm, "_value_b"}, 64'(cdb_value_out), 64'(e));
                        chk({nm, "_rob_b"}, 64'(cdb_rob_ix_out), 64'(e[2:0]));
                    end
                end
            end
            if (sa < n && fu_ready_out[a]) begin
                e = 32'((a << 16) | sa);
                set_fu(a, 1'b1, e[2:0], e, 32'(a));
                qa.push_back(e);
                sa++;
            end else begin
                if (sa < n) nra = 1;
                set_fu(a, 1'b0, 3'd0, 32'd0, 32'd0);
            end
            if (sb < n && fu_ready_out[b]) begin
                e = 32'((b << 16) | sb);
                set_fu(b, 1'b1, e[2:0], e, 32'(b));
                qb.push_back(e);
                sb++;
            end else begin
                if (sb < n) nrb = 1;
                set_fu(b, 1'b0, 3'd0, 32'd0, 32'd0);
            end
            tick();
            cyc++;
        end
        fu_valid_in = '0;
        chk({nm, "_all_received"}, 64'(got), 64'(2 * n));
        chk({nm, "_sb_empty"}, 64'(qa.size() + qb.size()), 64'd0);
        chk({nm, "_ready_a_dropped"}, 64'(nra), 64'd1);
        chk({nm, "_ready_b_dropped"}, 64'(nrb), 64'd1);
        tick();
        chk({nm, "_idle_after"}, 64'(cdb_valid_out), 64'd0);
    endtask

    initial begin
        rst_n_in     = 1'b0;
        flush_in     = 1'b0;
        fu_valid_in  = '0;
        fu_rob_ix_in = '0;
        fu_value_in  = '0;
        fu_dest_in   = '0;

        // Reset state, no clock edge yet
        #3;
        chk("rst_valid", 64'(cdb_valid_out), 64'd0);
        chk("rst_ready", 64'(fu_ready_out), 64'h0);
        chk("rst_value", 64'(cdb_value_out), 64'd0);
        chk("rst_src", 64'(cdb_src_out), 64'd0);
        tick(); tick();
        rst_n_in = 1'b1;
        #1;
        chk("post_rst_ready", 64'(fu_ready_out), 64'hf);

        // Single result from FU1: two-edge latency, one-cycle pulse
        set_fu(1, 1'b1, 3'd5, 32'h1234, 32'd7);
        tick();
        fu_valid_in = '0;
        chk("t1_not_yet", 64'(cdb_valid_out), 64'd0);
        tick();
        chk("t1_valid", 64'(cdb_valid_out), 64'd1);
        chk("t1_rob", 64'(cdb_rob_ix_out), 64'd5);
        chk("t1_value", 64'(cdb_value_out), 64'h1234);
        chk("t1_dest", 64'(cdb_dest_out), 64'd7);
        chk("t1_src", 64'(cdb_src_out), 64'd1);
        tick();
        chk("t1_pulse_end", 64'(cdb_valid_out), 64'd0);
        chk("t1_value_hold", 64'(cdb_value_out), 64'h1234);

        // Flush to bring rr_ptr back to 0, then all four push together
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        for (int k = 0; k < 4; k++) set_fu(k, 1'b1, 3'(k), 32'(32'h100 + k), 32'(k));
        tick();
        fu_valid_in = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_valid", 64'(cdb_valid_out), 64'd1);
            chk("t2_src", 64'(cdb_src_out), 64'(k));
            chk("t2_rob", 64'(cdb_rob_ix_out), 64'(k));
            chk("t2_value", 64'(cdb_value_out), 64'(32'h100 + k));
        end
        tick();
        chk("t2_drained", 64'(cdb_valid_out), 64'd0);

        // FU0 and FU2 stream with backpressure
        run_pair("t3", 0, 2, 6);

        // Flush while FU3 pushes: FU3 result must vanish
        for (int k = 0; k < 3; k++) set_fu(k, 1'b1, 3'(k + 1), 32'(32'h300 + k), 32'(k));
        tick();
        fu_valid_in = '0;
        flush_in    = 1'b1;
        set_fu(3, 1'b1, 3'd6, 32'hdead, 32'd3);
        tick();
        flush_in    = 1'b0;
        fu_valid_in = '0;
        chk("t4_valid_flush", 64'(cdb_valid_out), 64'd0);
        chk("t4_ready", 64'(fu_ready_out), 64'hf);
        tick();
        chk("t4_no_bcast1", 64'(cdb_valid_out), 64'd0);
        tick();
        chk("t4_no_bcast2", 64'(cdb_valid_out), 64'd0);

        // Reset dropped between edges during a burst
        for (int k = 0; k < 4; k++) set_fu(k, 1'b1, 3'(k + 4), 32'(32'h500 + k), 32'(k + 8));
        tick();
        fu_valid_in = '0;
        tick();
        chk("t5_burst_valid", 64'(cdb_valid_out), 64'd1);
        chk("t5_burst_src", 64'(cdb_src_out), 64'd0);
        chk("t5_burst_value", 64'(cdb_value_out), 64'h500);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(cdb_valid_out), 64'd0);
        chk("t5_rst_rob", 64'(cdb_rob_ix_out), 64'd0);
        chk("t5_rst_value", 64'(cdb_value_out), 64'd0);
        chk("t5_rst_dest", 64'(cdb_dest_out), 64'd0);
        chk("t5_rst_src", 64'(cdb_src_out), 64'd0);
        chk("t5_rst_ready", 64'(fu_ready_out), 64'h0);
        tick();
        rst_n_in = 1'b1;
        #1;
        chk("t5_rel_ready", 64'(fu_ready_out), 64'hf);
        set_fu(1, 1'b1, 3'd5, 32'h1234, 32'd7);
        tick();
        fu_valid_in = '0;
        chk("t5_not_yet", 64'(cdb_valid_out), 64'd0);
        tick();
        chk("t5_valid", 64'(cdb_valid_out), 64'd1);
        chk("t5_src", 64'(cdb_src_out), 64'd1);
        chk("t5_rob", 64'(cdb_rob_ix_out), 64'd5);
        chk("t5_value", 64'(cdb_value_out), 64'h1234);
        tick();
        chk("t5_old_lost", 64'(cdb_valid_out), 64'd0);

        // FU0 and FU3 contend continuously; neither starves
        run_pair("t6", 0, 3, 8);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
